usb_out_ep_buffer: RTL

Single-packet OUT endpoint buffer between the USB protocol engine's receive path and an OUT endpoint consumer such as the DFU control endpoint. It captures one DATA packet, answers the host with ACK/NAK/STALL, and tracks the DATA0/DATA1 toggle. It then presents the bytes to the consumer through the req/grant/data_avail/data_get handshake, and pulses `out_ep_acked` when a packet has been accepted.

---
 rtl/usb_out_ep_buffer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_out_ep_buffer.sv
// Single-packet OUT endpoint buffer: captures one DATA packet from the USB receive path,
// returns ACK/NAK/STALL, tracks the data toggle and hands the bytes to an endpoint consumer.
module usb_out_ep_buffer #(
  parameter int MAX_OUT_PACKET_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pkt_start,
  input  logic       rx_setup,
  input  logic       rx_pid_data1,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_valid,
  output logic       hs_valid,
  output logic [1:0] hs_pid,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  localparam int AW = $clog2(MAX_OUT_PACKET_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] MAX_PTR = PW'(MAX_OUT_PACKET_SIZE);

  localparam logic [1:0] HS_NONE  = 2'd0;
  localparam logic [1:0] HS_ACK   = 2'd1;
  localparam logic [1:0] HS_NAK   = 2'd2;
  localparam logic [1:0] HS_STALL = 2'd3;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PUTTING = 2'd1,
    GETTING = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [MAX_OUT_PACKET_SIZE];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] length;
  logic          overflow;
  logic          setup_flag;
  logic          toggle;
  logic          toggle_next;
  logic          ignoring;
  logic          ignore_set;
  logic          start_put;
  logic          accept;
  logic          hs_valid_next;
  logic [1:0]    hs_pid_next;
  logic          do_write;
  logic          do_get;

  assign out_ep_grant      = out_ep_req && (state == GETTING);
  assign out_ep_data_avail = (state == GETTING) && (rptr < length);
  assign out_ep_setup      = setup_flag;
  assign do_get            = out_ep_data_get && out_ep_grant && out_ep_data_avail;
  assign do_write          = (state == PUTTING) && rx_data_put && (wptr != MAX_PTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    start_put     = 1'b0;
    accept        = 1'b0;
    ignore_set    = 1'b0;
    toggle_next   = toggle;
    hs_valid_next = 1'b0;
    hs_pid_next   = HS_NONE;
    case (state)
      READY: begin
        if (rx_pkt_start) begin
          state_next = PUTTING;
          start_put  = 1'b1;
        end
      end
      PUTTING: begin
        if (rx_pkt_end) begin
          state_next = READY;
          if (!rx_pkt_valid) begin
            hs_valid_next = 1'b0;
          end else if (overflow) begin
            hs_valid_next = 1'b1;
            hs_pid_next   = HS_NAK;
          end else if (!setup_flag && out_ep_stall) begin
            hs_valid_next = 1'b1;
            hs_pid_next   = HS_STALL;
          end else if (setup_flag) begin
            hs_valid_next = 1'b1;
            if (rx_pid_data1) begin
              hs_pid_next = HS_NAK;
            end else begin
              hs_pid_next = HS_ACK;
              toggle_next = 1'b1;
              accept      = 1'b1;
              state_next  = GETTING;
            end
          end else if (rx_pid_data1 == toggle) begin
            hs_valid_next = 1'b1;
            hs_pid_next   = HS_ACK;
            toggle_next   = ~toggle;
            accept        = 1'b1;
            state_next    = GETTING;
          end else begin
            // Host retransmission of a packet already accepted: ACK it but drop the data.
            hs_valid_next = 1'b1;
            hs_pid_next   = HS_ACK;
          end
        end
      end
      GETTING: begin
        if (rx_pkt_start && rx_setup) begin
          state_next = PUTTING;
          start_put  = 1'b1;
        end else if (rx_pkt_start) begin
          ignore_set = 1'b1;
        end else if (rptr == length) begin
          state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
    // An OUT packet that arrived while the buffer was still held is refused once it ends.
    if (ignoring && rx_pkt_end) begin
      hs_valid_next = 1'b1;
      hs_pid_next   = HS_NAK;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      length       <= '0;
      overflow     <= 1'b0;
      setup_flag   <= 1'b0;
      toggle       <= 1'b0;
      ignoring     <= 1'b0;
      hs_valid     <= 1'b0;
      hs_pid       <= HS_NONE;
      out_ep_acked <= 1'b0;
      out_ep_data  <= 8'd0;
    end else begin
      hs_valid     <= hs_valid_next;
      hs_pid       <= hs_pid_next;
      out_ep_acked <= accept;
      toggle       <= toggle_next;

      if (start_put) begin
        wptr       <= '0;
        overflow   <= 1'b0;
        setup_flag <= rx_setup;
      end else if ((state == PUTTING) && rx_data_put) begin
        if (wptr == MAX_PTR) begin
          overflow <= 1'b1;
        end else begin
          wptr <= wptr + PW'(1);
        end
      end

      if (accept) begin
        length <= wptr;
      end

      if (ignore_set) begin
        ignoring <= 1'b1;
      end else if (rx_pkt_end) begin
        ignoring <= 1'b0;
      end

      if (do_get) begin
        out_ep_data <= mem[rptr[AW-1:0]];
      end

      if (start_put) begin
        rptr <= '0;
      end else if (do_get) begin
        rptr <= rptr + PW'(1);
      end else if ((state == GETTING) && (state_next == READY)) begin
        rptr <= '0;
      end
    end
  end

endmodule
